store_writeback: RTL and testbench

//  Store stage of the pipeline CPU: the writer into data memory. It accepts {result, addressResult}

---
 rtl/store_writeback_if.sv | 25 ++
 rtl/store_writeback.sv | 71 +++++++
 tb/tb_store_writeback.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/store_writeback_if.sv
// store_writeback_if: store handshake, debug read port and status bundle of the store stage
interface store_writeback_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          st_valid;
    logic          st_ready;
    logic [DW-1:0] st_data;
    logic [AW-1:0] st_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    pending;
    logic [15:0]   store_count;
    logic          overflow;
    modport master (
        output st_valid, st_data, st_addr, rd_en, rd_addr,
        input  st_ready, rd_data, rd_valid, pending, store_count, overflow
    );
    modport slave (
        input  st_valid, st_data, st_addr, rd_en, rd_addr,
        output st_ready, rd_data, rd_valid, pending, store_count, overflow
    );
endinterface

// File: rtl/store_writeback.sv
// store_writeback: buffers stores in a FIFO and drains them into data memory; debug reads win the port
module store_writeback #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input logic              CLOCK_50,
    input logic              reset,
    store_writeback_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   store_count_q, store_count_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [DW-1:0] fifo_data [DEPTH];
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] mem [2**AW];
    logic          accept, drain;
    assign bus.st_ready    = count_q != CW'(DEPTH);
    assign bus.pending     = 3'(count_q);
    assign bus.store_count = store_count_q;
    assign bus.overflow    = overflow_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    // Port arbitration: a debug read blocks the drain; otherwise the head entry commits
    always_comb begin
        accept        = bus.st_valid && bus.st_ready;
        drain         = !bus.rd_en && count_q != '0;
        wr_ptr_d      = wr_ptr_q + PW'(accept);
        rd_ptr_d      = rd_ptr_q + PW'(drain);
        count_d       = count_q + CW'(accept) - CW'(drain);
        store_count_d = store_count_q + 16'(drain);
        overflow_d    = overflow_q || (bus.st_valid && !bus.st_ready);
        rd_valid_d    = bus.rd_en;
        rd_data_d     = bus.rd_en ? mem[bus.rd_addr] : rd_data_q;
    end
    // Control state; reset discards queued entries
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            store_count_q <= '0;
            overflow_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            store_count_q <= store_count_d;
            overflow_q    <= overflow_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
    end
    // FIFO slots and data memory are never cleared; writes are suppressed during reset
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            if (accept) begin
                fifo_data[wr_ptr_q] <= bus.st_data;
                fifo_addr[wr_ptr_q] <= bus.st_addr;
            end
            if (drain) mem[fifo_addr[rd_ptr_q]] <= fifo_data[rd_ptr_q];
        end
    end
endmodule

// File: tb/tb_store_writeback.sv
// tb_store_writeback: directed checks of enqueue, drain, read priority, reset and counter wrap
module tb_store_writeback;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    store_writeback_if #(.AW(8), .DW(32)) bus ();
    store_writeback #(.DEPTH(4), .AW(8), .DW(32)) dut (.CLOCK_50(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic store(input logic [7:0] a, input logic [31:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        tick();
        bus.st_valid = 1'b0;
    endtask
    task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk(tag, bus.rd_data, exp);
    endtask
    initial begin
        reset        = 1'b1;
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_ready", 32'(bus.st_ready), 32'd1);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", bus.rd_data, 32'd0);
        chk("rst_count", 32'(bus.store_count), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        // T1: single store, commit one edge later, readback
        store(8'h05, 32'h12345678);
        chk("t1_pending_after_accept", 32'(bus.pending), 32'd1);
        chk("t1_count_before_commit", 32'(bus.store_count), 32'd0);
        tick();
        chk("t1_pending_after_commit", 32'(bus.pending), 32'd0);
        tick();
        read_chk("t1_read", 8'h05, 32'h12345678);
        chk("t1_count", 32'(bus.store_count), 32'd1);
        tick();
        chk("t1_rd_valid_drop", 32'(bus.rd_valid), 32'd0);
        chk("t1_rd_data_hold", bus.rd_data, 32'h12345678);
        // T2: reads starve the drain; fifth store is refused and flags overflow
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'h05;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) chk("t2_ready_open", 32'(bus.st_ready), 32'd1);
            store(8'h30 + 8'(i), 32'h100 + 32'(i));
        end
        chk("t2_pending_full", 32'(bus.pending), 32'd4);
        chk("t2_ready_closed", 32'(bus.st_ready), 32'd0);
        chk("t2_overflow", 32'(bus.overflow), 32'd1);
        chk("t2_count_starved", 32'(bus.store_count), 32'd1);
        bus.rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_drain_pending", 32'(bus.pending), 32'(3 - i));
            chk("t2_drain_count", 32'(bus.store_count), 32'(2 + i));
        end
        for (int i = 0; i < 4; i++) read_chk("t2_read", 8'h30 + 8'(i), 32'h100 + 32'(i));
        chk("t2_overflow_sticky", 32'(bus.overflow), 32'd1);
        // T3: same address twice, last store wins
        store(8'h10, 32'hAAAA0000);
        store(8'h10, 32'h0000BBBB);
        chk("t3_pending_overlap", 32'(bus.pending), 32'd1);
        tick();
        read_chk("t3_read", 8'h10, 32'h0000BBBB);
        chk("t3_count", 32'(bus.store_count), 32'd7);
        // T4: no forwarding from the FIFO to the debug read
        store(8'h20, 32'h11111111);
        tick();
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'h20;
        store(8'h20, 32'h22222222);
        tick();
        chk("t4_first_read_old", bus.rd_data, 32'h11111111);
        chk("t4_pending_starved", 32'(bus.pending), 32'd1);
        bus.rd_en = 1'b0;
        tick();
        chk("t4_second_read_old", bus.rd_data, 32'h11111111);
        chk("t4_pending_drained", 32'(bus.pending), 32'd0);
        tick();
        read_chk("t4_read_new", 8'h20, 32'h22222222);
        chk("t4_count", 32'(bus.store_count), 32'd9);
        // T5: reset with queued entries discards them without writing
        bus.rd_en   = 1'b1;
        bus.rd_addr = 8'h00;
        for (int i = 0; i < 3; i++) store(8'h30 + 8'(i), 32'hDEAD0000 + 32'(i));
        chk("t5_pending_before", 32'(bus.pending), 32'd3);
        bus.rd_en = 1'b0;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_pending", 32'(bus.pending), 32'd0);
        chk("t5_count", 32'(bus.store_count), 32'd0);
        chk("t5_overflow", 32'(bus.overflow), 32'd0);
        chk("t5_ready", 32'(bus.st_ready), 32'd1);
        chk("t5_rd_valid", 32'(bus.rd_valid), 32'd0);
        tick();
        chk("t5_no_late_drain", 32'(bus.store_count), 32'd0);
        for (int i = 0; i < 3; i++) read_chk("t5_mem_kept", 8'h30 + 8'(i), 32'h100 + 32'(i));
        // T6: store_count wraps from 0xFFFF to 0
        bus.st_valid = 1'b1;
        bus.st_addr  = 8'h50;
        for (int i = 0; i < 65535; i++) begin
            bus.st_data = 32'(i);
            tick();
        end
        bus.st_valid = 1'b0;
        tick();
        chk("t6_count_max", 32'(bus.store_count), 32'h0000FFFF);
        chk("t6_pending", 32'(bus.pending), 32'd0);
        read_chk("t6_last_data", 8'h50, 32'd65534);
        store(8'h51, 32'h0BADCAFE);
        tick();
        chk("t6_count_wrap", 32'(bus.store_count), 32'd0);
        chk("t6_overflow_clear", 32'(bus.overflow), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
